uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 132 +++++++++++++
 tb/tb_uart_rx.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, framing-error detection
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic [7:0] o_rx_d,
    output logic       o_rx_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e        state_q, state_d;
    logic          sync1_q, rx_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_d_q, rx_d_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    // Synchronisers reset to 1 so a reset never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            rx_d_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= i_rx;
            rx_s_q  <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rx_d_q  <= rx_d_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rx_d_d  = rx_d_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        rx_d_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            // A line held low must return high before a new start bit counts.
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_busy      = (state_q != S_IDLE);
        o_rx_d      = rx_d_q;
        o_rx_valid  = valid_q;
        o_frame_err = err_q;
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a waveform-sampling reference model
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_rx = 1'b1;
    logic [7:0] o_rx_d;
    logic       o_rx_valid;
    logic       o_frame_err;
    logic       o_busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rx       (i_rx),
        .o_rx_d     (o_rx_d),
        .o_rx_valid (o_rx_valid),
        .o_frame_err(o_frame_err),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle observations, sampled at the falling edge after rising edge number cyc.
    int         got_v_cyc[$];
    logic [7:0] got_v_dat[$];
    int         got_e_cyc[$];
    int         both_cnt = 0;
    logic       busy_log[65536];
    logic [7:0] rxd_log[65536];

    always @(negedge clk) begin
        busy_log[cyc % 65536] = o_busy;
        rxd_log[cyc % 65536]  = o_rx_d;
        if (o_rx_valid) begin
            got_v_cyc.push_back(cyc);
            got_v_dat.push_back(o_rx_d);
        end
        if (o_frame_err) got_e_cyc.push_back(cyc);
        if (o_rx_valid && o_frame_err) both_cnt++;
    end

    function automatic logic busy_at(input int c);
        return busy_log[c % 65536];
    endfunction

    function automatic logic [7:0] rxd_at(input int c);
        return rxd_log[c % 65536];
    endfunction

    // Line waveform: one entry per clock, entry i is captured at rising edge base+i.
    logic wave_q[$];

    task automatic add_level(input logic v, input int n);
        for (int i = 0; i < n; i++) wave_q.push_back(v);
    endtask

    task automatic add_frame(input logic [7:0] d, input int p, input logic stop);
        add_level(1'b0, p);
        for (int k = 0; k < 8; k++) add_level(d[k], p);
        add_level(stop, p);
    endtask

    task automatic clear_got();
        got_v_cyc.delete();
        got_v_dat.delete();
        got_e_cyc.delete();
    endtask

    task automatic play(output int base);
        base = 0;
        for (int i = 0; i < wave_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) base = cyc + 1;
            i_rx = wave_q[i];
        end
    endtask

    // Reference model: walk the waveform applying the receiver's timing rules
    // (detect two edges after a low capture, sample half a bit later, then every bit period).
    int         exp_v_cyc[$];
    logic [7:0] exp_v_dat[$];
    int         exp_e_cyc[$];
    int         exp_brk_exit[$];
    logic [7:0] exp_rx_d = 8'h00;

    function automatic logic line_at(input int i);
        return (i < wave_q.size()) ? wave_q[i] : 1'b1;
    endfunction

    task automatic run_model(input int base);
        int         i;
        int         stop_idx;
        int         j;
        logic [7:0] d;
        exp_v_cyc.delete();
        exp_v_dat.delete();
        exp_e_cyc.delete();
        exp_brk_exit.delete();
        i = 0;
        while (i < wave_q.size()) begin
            if (line_at(i)) begin
                i++;
            end else if (line_at(i + HALF)) begin
                i = i + HALF + 1;
            end else begin
                for (int k = 0; k < 8; k++) d[k] = line_at(i + HALF + (k + 1) * CPB);
                stop_idx = i + HALF + 9 * CPB;
                if (line_at(stop_idx)) begin
                    exp_v_cyc.push_back(base + stop_idx + 2);
                    exp_v_dat.push_back(d);
                    exp_rx_d = d;
                    i = stop_idx + 1;
                end else begin
                    exp_e_cyc.push_back(base + stop_idx + 2);
                    j = stop_idx + 1;
                    while (!line_at(j)) j++;
                    exp_brk_exit.push_back(base + j + 2);
                    i = j + 1;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_rx  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_rx_d, o_rx_valid, o_frame_err, o_busy} !== 11'h0) begin
            failures++;
            $display("FAIL reset_held got=%h exp=000", {o_rx_d, o_rx_valid, o_frame_err, o_busy});
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if ({o_rx_d, o_rx_valid, o_frame_err, o_busy} !== 11'h0) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=000", {o_rx_d, o_rx_valid, o_frame_err, o_busy});
        end
        exp_rx_d = 8'h00;
    endtask

    task automatic test_single();
        int base;
        wave_q.delete();
        add_frame(8'hA5, CPB, 1'b1);
        add_level(1'b1, 40);
        clear_got();
        play(base);
        exp_rx_d = 8'hA5;
        checks++;
        if (got_v_cyc.size() != 1) begin
            failures++;
            $display("FAIL single_count got=%0d exp=1", got_v_cyc.size());
        end
        checks++;
        if (got_v_cyc.size() > 0 && (got_v_cyc[0] !== base + 154 || got_v_dat[0] !== 8'hA5)) begin
            failures++;
            $display("FAIL single_pulse got=cyc%0d/%h exp=cyc%0d/a5", got_v_cyc[0], got_v_dat[0], base + 154);
        end
        checks++;
        if (got_e_cyc.size() != 0) begin
            failures++;
            $display("FAIL single_err got=%0d exp=0", got_e_cyc.size());
        end
        checks++;
        if ({busy_at(base + 1), busy_at(base + 2), busy_at(base + 153), busy_at(base + 154)} !== 4'b0110) begin
            failures++;
            $display("FAIL single_busy got=%b exp=0110",
                     {busy_at(base + 1), busy_at(base + 2), busy_at(base + 153), busy_at(base + 154)});
        end
        checks++;
        if (o_rx_d !== 8'hA5) begin
            failures++;
            $display("FAIL single_hold got=%h exp=a5", o_rx_d);
        end
    endtask

    task automatic test_random();
        int base;
        int nf;
        for (int it = 0; it < 5; it++) begin
            wave_q.delete();
            nf = int'($urandom_range(1, 3));
            for (int f = 0; f < nf; f++) begin
                add_level(1'b1, int'($urandom_range(0, 12)));
                add_frame(8'($urandom_range(0, 255)), CPB, ($urandom_range(0, 3) != 0));
            end
            add_level(1'b1, 40);
            clear_got();
            play(base);
            repeat (200) @(negedge clk);
            run_model(base);
            checks++;
            if (got_v_cyc.size() != exp_v_cyc.size() || got_e_cyc.size() != exp_e_cyc.size()) begin
                failures++;
                $display("FAIL random_count it=%0d got=%0d/%0d exp=%0d/%0d", it,
                         got_v_cyc.size(), got_e_cyc.size(), exp_v_cyc.size(), exp_e_cyc.size());
            end
            for (int k = 0; k < exp_v_cyc.size() && k < got_v_cyc.size(); k++) begin
                checks++;
                if (got_v_cyc[k] !== exp_v_cyc[k] || got_v_dat[k] !== exp_v_dat[k]) begin
                    failures++;
                    $display("FAIL random_valid it=%0d k=%0d got=cyc%0d/%h exp=cyc%0d/%h", it, k,
                             got_v_cyc[k], got_v_dat[k], exp_v_cyc[k], exp_v_dat[k]);
                end
            end
            for (int k = 0; k < exp_e_cyc.size() && k < got_e_cyc.size(); k++) begin
                checks++;
                if (got_e_cyc[k] !== exp_e_cyc[k]) begin
                    failures++;
                    $display("FAIL random_err it=%0d k=%0d got=cyc%0d exp=cyc%0d", it, k, got_e_cyc[k], exp_e_cyc[k]);
                end
            end
            checks++;
            if (o_rx_d !== exp_rx_d) begin
                failures++;
                $display("FAIL random_hold it=%0d got=%h exp=%h", it, o_rx_d, exp_rx_d);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        wave_q.delete();
        add_frame(8'h00, CPB, 1'b1);
        add_frame(8'hFF, CPB, 1'b1);
        add_level(1'b1, 40);
        clear_got();
        play(base);
        exp_rx_d = 8'hFF;
        checks++;
        if (got_v_cyc.size() != 2) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=2", got_v_cyc.size());
        end else begin
            checks++;
            if (got_v_dat[0] !== 8'h00 || got_v_dat[1] !== 8'hFF) begin
                failures++;
                $display("FAIL b2b_data got=%h,%h exp=00,ff", got_v_dat[0], got_v_dat[1]);
            end
            checks++;
            if (got_v_cyc[0] !== base + 154 || got_v_cyc[1] - got_v_cyc[0] !== 160) begin
                failures++;
                $display("FAIL b2b_timing got=cyc%0d,gap%0d exp=cyc%0d,gap160", got_v_cyc[0],
                         got_v_cyc[1] - got_v_cyc[0], base + 154);
            end
        end
        checks++;
        if (got_e_cyc.size() != 0) begin
            failures++;
            $display("FAIL b2b_err got=%0d exp=0", got_e_cyc.size());
        end
    endtask

    task automatic test_glitch();
        int base;
        wave_q.delete();
        add_level(1'b0, 4);
        add_level(1'b1, 40);
        clear_got();
        play(base);
        checks++;
        if (got_v_cyc.size() != 0 || got_e_cyc.size() != 0) begin
            failures++;
            $display("FAIL glitch_pulses got=%0d/%0d exp=0/0", got_v_cyc.size(), got_e_cyc.size());
        end
        checks++;
        if ({busy_at(base + 2), busy_at(base + 9), busy_at(base + 10)} !== 3'b110) begin
            failures++;
            $display("FAIL glitch_busy got=%b exp=110", {busy_at(base + 2), busy_at(base + 9), busy_at(base + 10)});
        end
        checks++;
        if (o_rx_d !== exp_rx_d) begin
            failures++;
            $display("FAIL glitch_hold got=%h exp=%h", o_rx_d, exp_rx_d);
        end
    endtask

    task automatic test_break();
        int base;
        int exit_cyc;
        wave_q.delete();
        add_frame(8'h3C, CPB, 1'b0);
        add_level(1'b0, 40);
        add_level(1'b1, 30);
        add_frame(8'h5A, CPB, 1'b1);
        add_level(1'b1, 40);
        clear_got();
        play(base);
        run_model(base);
        exit_cyc = (exp_brk_exit.size() > 0) ? exp_brk_exit[0] : base + 202;
        checks++;
        if (got_e_cyc.size() != 1 || (got_e_cyc.size() > 0 && got_e_cyc[0] !== base + 154)) begin
            failures++;
            $display("FAIL break_err got=%0d pulses first=cyc%0d exp=1 at cyc%0d", got_e_cyc.size(),
                     (got_e_cyc.size() > 0) ? got_e_cyc[0] : -1, base + 154);
        end
        checks++;
        if (rxd_at(base + 155) !== 8'hFF) begin
            failures++;
            $display("FAIL break_keep got=%h exp=ff", rxd_at(base + 155));
        end
        checks++;
        if ({busy_at(base + 190), busy_at(exit_cyc - 1), busy_at(exit_cyc)} !== 3'b110) begin
            failures++;
            $display("FAIL break_hold got=%b exp=110", {busy_at(base + 190), busy_at(exit_cyc - 1), busy_at(exit_cyc)});
        end
        checks++;
        if (got_v_cyc.size() != 1 || exp_v_cyc.size() != 1) begin
            failures++;
            $display("FAIL break_next_count got=%0d exp=1", got_v_cyc.size());
        end else begin
            checks++;
            if (got_v_dat[0] !== 8'h5A || got_v_cyc[0] !== exp_v_cyc[0]) begin
                failures++;
                $display("FAIL break_next got=cyc%0d/%h exp=cyc%0d/5a", got_v_cyc[0], got_v_dat[0], exp_v_cyc[0]);
            end
        end
        exp_rx_d = 8'h5A;
    endtask

    task automatic test_reset_midframe();
        int base;
        wave_q.delete();
        add_level(1'b0, CPB);
        for (int k = 0; k < 4; k++) add_level((k == 0), CPB);
        add_level(1'b0, HALF);
        clear_got();
        play(base);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_rx_d, o_rx_valid, o_frame_err, o_busy} !== 11'h0) begin
            failures++;
            $display("FAIL midreset_async got=%h exp=000", {o_rx_d, o_rx_valid, o_frame_err, o_busy});
        end
        i_rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        exp_rx_d = 8'h00;
        checks++;
        if (got_v_cyc.size() != 0 || got_e_cyc.size() != 0 || o_busy !== 1'b0 || o_rx_d !== 8'h00) begin
            failures++;
            $display("FAIL midreset_quiet got=%0d/%0d busy=%b d=%h exp=0/0 busy=0 d=00",
                     got_v_cyc.size(), got_e_cyc.size(), o_busy, o_rx_d);
        end
        wave_q.delete();
        add_frame(8'h81, CPB, 1'b1);
        add_level(1'b1, 40);
        clear_got();
        play(base);
        run_model(base);
        checks++;
        if (got_v_cyc.size() != 1 || (got_v_cyc.size() > 0 && (got_v_dat[0] !== 8'h81 || got_v_cyc[0] !== base + 154))) begin
            failures++;
            $display("FAIL midreset_after got=%0d pulses first=%h exp=1 pulse 81 at cyc%0d", got_v_cyc.size(),
                     (got_v_dat.size() > 0) ? got_v_dat[0] : 8'hxx, base + 154);
        end
    endtask

    task automatic test_tolerance();
        int base;
        int periods[2] = '{17, 15};
        for (int t = 0; t < 2; t++) begin
            wave_q.delete();
            add_frame(8'hC3, periods[t], 1'b1);
            add_level(1'b1, 40);
            clear_got();
            play(base);
            run_model(base);
            checks++;
            if (got_v_cyc.size() != 1 || got_e_cyc.size() != 0) begin
                failures++;
                $display("FAIL tol_count p=%0d got=%0d/%0d exp=1/0", periods[t], got_v_cyc.size(), got_e_cyc.size());
            end else begin
                checks++;
                if (got_v_dat[0] !== 8'hC3 || exp_v_cyc.size() != 1 || got_v_cyc[0] !== exp_v_cyc[0]) begin
                    failures++;
                    $display("FAIL tol_data p=%0d got=cyc%0d/%h exp=cyc%0d/c3", periods[t], got_v_cyc[0],
                             got_v_dat[0], (exp_v_cyc.size() > 0) ? exp_v_cyc[0] : -1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_random();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_midframe();
        test_tolerance();
        checks++;
        if (both_cnt != 0) begin
            failures++;
            $display("FAIL exclusive_pulses got=%0d exp=0", both_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
